// File: rtl/sipo_in.sv
// Byte-serial input deserializer: MSB-first byte capture into a word, valid/ack output slot with a one-deep hold buffer.
// Optional trailing XOR checksum byte per frame when SIPO_IN_CHECKSUM_EN is defined.
module sipo_in #(
    parameter int NUM_BYTES = 4,
    parameter int CNT_W     = 3
) (
    input  logic                   CLKEXT,
    input  logic                   RST_GLO,
    input  logic                   EN_SIPO_IN,
    input  logic                   CLR_SIPO_IN,
    input  logic                   SHIFT_IN,
    input  logic [7:0]             D_IN,
    input  logic                   WORD_ACK,
    output logic [NUM_BYTES*8-1:0] WORD_OUT,
    output logic                   WORD_VALID,
    output logic [CNT_W-1:0]       BYTE_CNT,
    output logic                   BUSY,
    output logic                   OVERFLOW,
    output logic                   CSUM_ERR
);
    localparam int W = NUM_BYTES * 8;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           state_reg, state_next;
    logic [W-1:0]     shreg_reg, shreg_next;
    logic [W-1:0]     word_reg, word_next;
    logic             valid_reg, valid_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             ovf_reg, ovf_next;
    logic             accept;
    logic             slot_free;
    logic [W-1:0]     shifted;

`ifdef SIPO_IN_CHECKSUM_EN
    // The decision byte is the checksum that follows the last data byte.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BYTES);
    logic [7:0] xor_reg, xor_next;
    logic       err_reg, err_next;
`else
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BYTES - 1);
`endif

    assign accept    = EN_SIPO_IN && SHIFT_IN && (state_reg == FILL);
    assign slot_free = !valid_reg || WORD_ACK;
    assign shifted   = {shreg_reg[W-9:0], D_IN};

    always_comb begin
        state_next = state_reg;
        shreg_next = shreg_reg;
        word_next  = word_reg;
        valid_next = valid_reg;
        cnt_next   = cnt_reg;
        ovf_next   = ovf_reg;
`ifdef SIPO_IN_CHECKSUM_EN
        xor_next   = xor_reg;
        err_next   = err_reg;
`endif
        if (valid_reg && WORD_ACK)
            valid_next = 1'b0;

        if (state_reg == HOLD) begin
            if (EN_SIPO_IN && SHIFT_IN)
                ovf_next = 1'b1;
            // Slot is occupied in HOLD, so an ack swaps the held word straight in.
            if (WORD_ACK) begin
                word_next  = shreg_reg;
                valid_next = 1'b1;
                cnt_next   = '0;
                state_next = FILL;
            end
        end else if (accept) begin
`ifdef SIPO_IN_CHECKSUM_EN
            if (cnt_reg == LAST_CNT) begin
                if (D_IN == xor_reg) begin
                    if (slot_free) begin
                        word_next  = shreg_reg;
                        valid_next = 1'b1;
                        cnt_next   = '0;
                    end else begin
                        state_next = HOLD;
                    end
                end else begin
                    err_next = 1'b1;
                    cnt_next = '0;
                end
            end else begin
                shreg_next = shifted;
                cnt_next   = cnt_reg + CNT_W'(1);
                xor_next   = (cnt_reg == '0) ? D_IN : (xor_reg ^ D_IN);
            end
`else
            shreg_next = shifted;
            if (cnt_reg == LAST_CNT) begin
                if (slot_free) begin
                    word_next  = shifted;
                    valid_next = 1'b1;
                    cnt_next   = '0;
                end else begin
                    state_next = HOLD;
                    cnt_next   = CNT_W'(NUM_BYTES);
                end
            end else begin
                cnt_next = cnt_reg + CNT_W'(1);
            end
`endif
        end
    end

    always_ff @(posedge CLKEXT) begin
        if (RST_GLO || CLR_SIPO_IN) begin
            state_reg <= FILL;
            shreg_reg <= '0;
            word_reg  <= '0;
            valid_reg <= 1'b0;
            cnt_reg   <= '0;
            ovf_reg   <= 1'b0;
`ifdef SIPO_IN_CHECKSUM_EN
            xor_reg   <= '0;
            err_reg   <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            shreg_reg <= shreg_next;
            word_reg  <= word_next;
            valid_reg <= valid_next;
            cnt_reg   <= cnt_next;
            ovf_reg   <= ovf_next;
`ifdef SIPO_IN_CHECKSUM_EN
            xor_reg   <= xor_next;
            err_reg   <= err_next;
`endif
        end
    end

    assign WORD_OUT   = word_reg;
    assign WORD_VALID = valid_reg;
    assign BYTE_CNT   = cnt_reg;
    assign BUSY       = (state_reg == HOLD);
    assign OVERFLOW   = ovf_reg;
`ifdef SIPO_IN_CHECKSUM_EN
    assign CSUM_ERR   = err_reg;
`else
    assign CSUM_ERR   = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_in.sv
// Testbench for sipo_in: frame-queue reference model checked every cycle, directed literal checks, random traffic.
module tb_sipo_in;
    localparam int NB = 4;
    localparam int CW = 3;
    localparam int W  = NB * 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1, en = 1'b0, clr = 1'b0, shift = 1'b0, ack = 1'b0;
    logic [7:0]    d = '0;
    logic [W-1:0]  word_out;
    logic          word_valid, busy, ovf, cerr;
    logic [CW-1:0] byte_cnt;

    int checks = 0;
    int errors = 0;
    int printed = 0;
    bit check_en = 0;

    sipo_in #(.NUM_BYTES(NB), .CNT_W(CW)) dut (
        .CLKEXT(clk), .RST_GLO(rst), .EN_SIPO_IN(en), .CLR_SIPO_IN(clr),
        .SHIFT_IN(shift), .D_IN(d), .WORD_ACK(ack),
        .WORD_OUT(word_out), .WORD_VALID(word_valid), .BYTE_CNT(byte_cnt),
        .BUSY(busy), .OVERFLOW(ovf), .CSUM_ERR(cerr)
    );

    always #5 clk = ~clk;

    // Reference model: bytes of the current frame in a queue, a pending-word flag, the output slot.
    logic [7:0]   m_q[$];
    logic [W-1:0] m_word = '0;
    logic [W-1:0] m_pend_word = '0;
    bit           m_valid = 0, m_pend = 0, m_ovf = 0, m_err = 0;

    always @(posedge clk) begin
        bit           v0;
        logic [W-1:0] w;
        logic [7:0]   x;
        if (rst || clr) begin
            m_q.delete();
            m_word = '0; m_valid = 0; m_pend = 0; m_ovf = 0; m_err = 0;
        end else begin
            v0 = m_valid;
            if (m_pend) begin
                if (en && shift) m_ovf = 1;
                if (ack) begin
                    m_word = m_pend_word;
                    m_pend = 0;
                    m_q.delete();
                end
            end else begin
                if (v0 && ack) m_valid = 0;
                if (en && shift) begin
                    w = '0;
                    x = '0;
`ifdef SIPO_IN_CHECKSUM_EN
                    if (m_q.size() < NB) begin
                        m_q.push_back(d);
                    end else begin
                        foreach (m_q[i]) begin
                            w = {w[W-9:0], m_q[i]};
                            x = x ^ m_q[i];
                        end
                        if (d == x) begin
                            if (!v0 || ack) begin
                                m_word = w; m_valid = 1; m_q.delete();
                            end else begin
                                m_pend = 1; m_pend_word = w;
                            end
                        end else begin
                            m_err = 1;
                            m_q.delete();
                        end
                    end
`else
                    m_q.push_back(d);
                    if (m_q.size() == NB) begin
                        foreach (m_q[i]) w = {w[W-9:0], m_q[i]};
                        if (!v0 || ack) begin
                            m_word = w; m_valid = 1; m_q.delete();
                        end else begin
                            m_pend = 1; m_pend_word = w;
                        end
                    end
`endif
                end
            end
        end
    end

    task automatic cmp(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (printed < 30) begin
                printed++;
                $display("FAIL %s actual=%h required=%h time=%0t", name, act, exp, $time);
            end
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            cmp("word_valid", W'(word_valid), W'(m_valid));
            cmp("word_out", word_out, m_word);
            cmp("byte_cnt", W'(byte_cnt), W'(m_q.size()));
            cmp("busy", W'(busy), W'(m_pend));
            cmp("overflow", W'(ovf), W'(m_ovf));
            cmp("csum_err", W'(cerr), W'(m_err));
        end
    end

    // Drive one cycle of inputs at the falling edge, return just after the next rising edge.
    task automatic drive(input bit r, input bit c, input bit e, input bit s,
                         input logic [7:0] b, input bit a);
        @(negedge clk);
        rst = r; clr = c; en = e; shift = s; d = b; ack = a;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input bit a);
        drive(0, 0, 1, 1, b, a);
        $display("byte %h ack=%0d -> valid=%0d word=%h cnt=%0d busy=%0d ovf=%0d",
                 b, a, word_valid, word_out, byte_cnt, busy, ovf);
    endtask

    logic [7:0] rb;
    bit         ra;
    int         ph;

    initial begin
        drive(1, 0, 0, 0, 8'h00, 0);
        check_en = 1;
        cmp("reset_valid", W'(word_valid), '0);
        cmp("reset_word", word_out, '0);
        cmp("reset_cnt", W'(byte_cnt), '0);
        cmp("reset_busy", W'(busy), '0);

`ifndef SIPO_IN_CHECKSUM_EN
        send(8'hAA, 1); send(8'hAA, 1);
        cmp("t1_cnt2", W'(byte_cnt), W'(2));
        send(8'h55, 1); send(8'h55, 1);
        cmp("t1_word", word_out, 32'hAAAA5555);
        cmp("t1_valid", W'(word_valid), W'(1));
        drive(0, 0, 1, 0, 8'h00, 1);
        cmp("t1_valid_one_cycle", W'(word_valid), '0);

        send(8'h12, 1); send(8'h34, 1); send(8'hAB, 1); send(8'hCD, 1);
        cmp("t2_word1", word_out, 32'h1234ABCD);
        cmp("t2_cnt_wrap", W'(byte_cnt), '0);
        send(8'hFF, 1);
        cmp("t2_cnt1", W'(byte_cnt), W'(1));
        send(8'hFF, 1); send(8'h00, 1); send(8'h00, 1);
        cmp("t2_word2", word_out, 32'hFFFF0000);
        cmp("t2_valid2", W'(word_valid), W'(1));
        drive(0, 0, 1, 0, 8'h00, 1);

        send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
        send(8'h55, 0); send(8'h66, 0); send(8'h77, 0); send(8'h88, 0);
        cmp("t3_busy", W'(busy), W'(1));
        cmp("t3_word_first", word_out, 32'h11223344);
        cmp("t3_cnt_full", W'(byte_cnt), W'(NB));
        send(8'h77, 0);
        cmp("t3_overflow", W'(ovf), W'(1));
        drive(0, 0, 1, 0, 8'h00, 1);
        cmp("t3_word_second", word_out, 32'h55667788);
        cmp("t3_valid", W'(word_valid), W'(1));
        cmp("t3_busy_clear", W'(busy), '0);
        drive(0, 0, 1, 0, 8'h00, 1);

        drive(1, 0, 0, 0, 8'h00, 0);
        send(8'h12, 1); send(8'h34, 1);
        drive(0, 1, 1, 0, 8'h00, 0);
        cmp("t4_cnt_clear", W'(byte_cnt), '0);
        send(8'hDE, 1); send(8'hAD, 1); send(8'hBE, 1); send(8'hEF, 1);
        cmp("t4_word", word_out, 32'hDEADBEEF);
        cmp("t4_overflow", W'(ovf), '0);
        drive(0, 0, 1, 0, 8'h00, 1);

        for (int i = 0; i < 6; i++) drive(0, 0, 0, 1, (i % 2 == 0) ? 8'h5A : 8'hA5, 0);
        cmp("t5_cnt", W'(byte_cnt), '0);
        cmp("t5_valid", W'(word_valid), '0);
        cmp("t5_overflow", W'(ovf), '0);
`else
        send(8'h12, 1); send(8'h34, 1); send(8'hAB, 1); send(8'hCD, 1); send(8'h40, 1);
        cmp("ck_word", word_out, 32'h1234ABCD);
        cmp("ck_valid", W'(word_valid), W'(1));
        cmp("ck_err0", W'(cerr), '0);
        send(8'h12, 1); send(8'h34, 1); send(8'hAB, 1); send(8'hCD, 1); send(8'h41, 1);
        cmp("ck_novalid", W'(word_valid), '0);
        cmp("ck_err1", W'(cerr), W'(1));
        cmp("ck_cnt0", W'(byte_cnt), '0);
        drive(1, 0, 0, 0, 8'h00, 0);
`endif

        for (int n = 0; n < 4000; n++) begin
            ph = (n / 400) % 3;
            rb = 8'($urandom);
`ifdef SIPO_IN_CHECKSUM_EN
            if (m_q.size() == NB && $urandom_range(0, 3) != 0) begin
                rb = '0;
                foreach (m_q[i]) rb = rb ^ m_q[i];
            end
`endif
            ra = (ph == 0) ? ($urandom_range(0, 9) != 0) :
                 (ph == 1) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 19) == 0);
            drive($urandom_range(0, 299) == 0, $urandom_range(0, 149) == 0,
                  $urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7, rb, ra);
        end
        drive(0, 0, 1, 0, 8'h00, 1);
        @(negedge clk);
        check_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
